traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Checker and decoder on the consumer side of the traffic-light `light` bus. Samples the 3-bit one-hot `light` code driven by the light controller every clock and decodes it into a phase. It validates code legality, phase ordering (YELLOW → GREEN → RED → YELLOW) and maximum dwell time, and counts completed light cycles. Sits beside the controller in system benches and silicon, feeding status and error flags to supervision logic.

## Interface
- `MAX_HOLD`, default 8 – maximum consecutive samples of one phase; legal range 1..255.
- `CNT_W`, default 8 – width of the completed-cycle counter.
- `clk` input, 1 – sampling clock, rising edge.
- `rst` input, 1 – reset, asynchronous, active-high.
- `light` input, 3 – controller output code: RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
- `err_clr` input, 1 – synchronous clear of `err_sticky`.
- `in_sync` output, 1 – monitor is tracking a legal phase.
- `phase` output, 2 – decoded phase: 00 none, 01 RED, 10 YELLOW, 11 GREEN.
- `err_onehot` output, 1 – one-cycle pulse for a non-one-hot code (includes 000).
- `err_seq` output, 1 – one-cycle pulse for an illegal phase successor.
- `err_hold` output, 1 – one-cycle pulse for a dwell exceeding `MAX_HOLD`.
- `err_sticky` output, 1 – OR of all error pulses, held until cleared.
- `cycle_cnt` output, CNT_W – completed cycles (GREEN→RED transitions), wraps.

## Operation
- States:
  - SYNC: no phase tracked. Reset state.
  - T_RED, T_YELLOW, T_GREEN: tracking that phase.
  - `phase` mirrors the state; SYNC gives 00.
- Hold counter `hold_cnt` has width ceil(log2(MAX_HOLD+1)). It counts samples of the current phase and saturates at MAX_HOLD.
- Per sample, in priority order:
  1. Code not one-hot → `err_onehot`=1, next state SYNC, `hold_cnt`=0.
  2. In SYNC with a one-hot code → enter the matching T_ state, `hold_cnt`=1, no error. This is how the monitor starts after reset or recovers after an error.
  3. Same code as the tracked phase:
     - If `hold_cnt`<MAX_HOLD, increment it.
     - Otherwise (with the hold check compiled in) assert `err_hold`, go to SYNC, set `hold_cnt`=0.
  4. Legal successor (RED→YELLOW, YELLOW→GREEN, GREEN→RED) → move to the new state, `hold_cnt`=1.
     - GREEN→RED also increments `cycle_cnt` modulo 2^CNT_W.
  5. Illegal successor (RED→GREEN, GREEN→YELLOW, YELLOW→RED) → `err_seq`=1. The new phase is adopted directly (resync in place), `hold_cnt`=1, `cycle_cnt` unchanged.
- At most one error pulse asserts per cycle.
- `err_sticky`:
  - Set on any error pulse; cleared by `err_clr`.
  - If `err_clr` and an error pulse occur in the same cycle, the set wins (`err_sticky`=1).
- `in_sync`=1 in every T_ state.

## Timing
- Every output is registered. `light` is sampled at rising edge k, and the response is visible after edge k, i.e. valid during cycle k+1. Latency is 1 cycle.
- `light` must be stable across the sampling edge; it comes from the same clock domain.
- Error pulses are exactly one cycle wide per offending sample. Back-to-back bad samples produce back-to-back pulses.
- Reset, effective immediately with no clock needed:
  - state SYNC, `phase`=00, `in_sync`=0.
  - All error outputs 0, `hold_cnt`=0, `cycle_cnt`=0.
- Reset asserted mid-cycle discards all history. The first sample after release follows the SYNC rules.
- `cycle_cnt` wraps from 2^CNT_W−1 to 0 without any flag.

## Configuration
- `TRAFFIC_LIGHT_MON_HOLD_CHECK_EN`:
  - Defined: the dwell check is active, `err_hold` behaves as described, and `hold_cnt` plus its compare are built.
  - Undefined: `hold_cnt` and its compare are not built, `err_hold` is tied to 0, and a phase may hold indefinitely with no error. All other behaviour is unchanged.

## Test plan
- Reset, then drive YELLOW, GREEN, RED repeating each cycle for 30 cycles:
  - `in_sync`=1 from the cycle after the first sample.
  - `cycle_cnt`=10 at the end.
  - No error pulses, `err_sticky`=0.
- While tracking, drive `light`=3'b011 for one sample, then YELLOW:
  - `err_onehot` pulses once; `phase`=00 and `in_sync`=0 for one cycle.
  - Then `phase`=10 (YELLOW); `err_sticky`=1.
- Drive RED then GREEN:
  - `err_seq` pulses on the GREEN sample, `phase`=11 (GREEN) in the same response cycle.
  - `cycle_cnt` unchanged.
- With `MAX_HOLD`=4 and the macro defined, hold RED for 5 samples:
  - `err_hold` pulses on the 5th sample's response, `phase`=00.
  - The 6th RED sample resyncs to `phase`=01.
  - Repeat with the macro undefined: no error.
- With `CNT_W`=2, run 5 full cycles: `cycle_cnt` reads 1,2,3,0,1. Assert `err_clr` on the same cycle as an injected `err_seq`: `err_sticky` stays 1. Clear on the next cycle: `err_sticky`=0.
- Assert `rst` asynchronously in mid-GREEN with `cycle_cnt`=3:
  - All outputs return to reset values before the next edge.
  - After release, RED is adopted without error and `cycle_cnt` restarts from 0.

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Consumer-side light bus: controller code in, decoded status out.
// The master drives the code and clear, the slave is the monitor.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       light;
  logic             err_clr;
  logic             in_sync;
  logic [1:0]       phase;
  logic             err_onehot;
  logic             err_seq;
  logic             err_hold;
  logic             err_sticky;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output light,
    output err_clr,
    input  in_sync,
    input  phase,
    input  err_onehot,
    input  err_seq,
    input  err_hold,
    input  err_sticky,
    input  cycle_cnt
  );

  modport slave (
    input  light,
    input  err_clr,
    output in_sync,
    output phase,
    output err_onehot,
    output err_seq,
    output err_hold,
    output err_sticky,
    output cycle_cnt
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Light bus checker: decodes phase, flags code/order/dwell errors.
// Dwell check built only with TRAFFIC_LIGHT_MON_HOLD_CHECK_EN defined.
module traffic_light_monitor #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD out of range 1..255");
  end

  // Encoding doubles as the phase output code
  typedef enum logic [1:0] {
    SYNC     = 2'b00,
    T_RED    = 2'b01,
    T_YELLOW = 2'b10,
    T_GREEN  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  state_e           code_st, succ_st;
  logic             onehot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eo_q, eo_d;
  logic             es_q, es_d;
  logic             eh_d;
  logic             sticky_q, sticky_d;

`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          eh_q;
`endif

  always_comb begin
    code_st = SYNC;
    onehot  = 1'b1;
    case (bus.light)
      3'b100:  code_st = T_RED;
      3'b010:  code_st = T_GREEN;
      3'b001:  code_st = T_YELLOW;
      default: onehot  = 1'b0;
    endcase
  end

  always_comb begin
    succ_st = SYNC;
    unique case (state_q)
      T_RED:    succ_st = T_YELLOW;
      T_YELLOW: succ_st = T_GREEN;
      T_GREEN:  succ_st = T_RED;
      default:  succ_st = SYNC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eo_d    = 1'b0;
    es_d    = 1'b0;
    eh_d    = 1'b0;
`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
    hold_d  = hold_q;
`endif
    if (!onehot) begin
      eo_d    = 1'b1;
      state_d = SYNC;
`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
      hold_d  = '0;
`endif
    end else if (state_q == SYNC) begin
      state_d = code_st;
`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
      hold_d  = HW'(1);
`endif
    end else if (code_st == state_q) begin
`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
      if (hold_q < HW'(MAX_HOLD)) begin
        hold_d = hold_q + HW'(1);
      end else begin
        eh_d    = 1'b1;
        state_d = SYNC;
        hold_d  = '0;
      end
`endif
    end else begin
      // Illegal successors resync in place onto the new phase
      state_d = code_st;
`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
      hold_d  = HW'(1);
`endif
      if (code_st == succ_st) begin
        if (state_q == T_GREEN)
          cnt_d = cnt_q + CNT_W'(1);
      end else begin
        es_d = 1'b1;
      end
    end
  end

  // A new error outranks a simultaneous clear
  assign sticky_d = eo_d | es_d | eh_d
                  | (sticky_q & ~bus.err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      eo_q     <= 1'b0;
      es_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      eo_q     <= eo_d;
      es_q     <= es_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      eh_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      eh_q   <= eh_d;
    end
  end

  assign bus.err_hold = eh_q;
`else
  assign bus.err_hold = 1'b0;
`endif

  assign bus.in_sync    = (state_q != SYNC);
  assign bus.phase      = state_q;
  assign bus.err_onehot = eo_q;
  assign bus.err_seq    = es_q;
  assign bus.err_sticky = sticky_q;
  assign bus.cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table plus scoreboard queue.
// Hold expectations follow TRAFFIC_LIGHT_MON_HOLD_CHECK_EN.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

`ifdef TRAFFIC_LIGHT_MON_HOLD_CHECK_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  typedef struct packed {
    logic       sync;
    logic [1:0] ph;
    logic       eo;
    logic       es;
    logic       eh;
    logic       st;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [2:0] light;
    logic       clr;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t tbl[16];

  traffic_light_monitor_if #(.CNT_W(8)) bus ();

  traffic_light_monitor #(
    .MAX_HOLD(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic       sync,
    input logic [1:0] ph,
    input logic       eo,
    input logic       es,
    input logic       eh,
    input logic       st,
    input logic [7:0] cnt
  );
    mk = '{sync, ph, eo, es, eh, st, cnt};
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t a;
    a = '{bus.in_sync, bus.phase, bus.err_onehot,
          bus.err_seq, bus.err_hold, bus.err_sticky,
          bus.cycle_cnt};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b/%b o%b s%b h%b k%b c%0d, want %b/%b o%b s%b h%b k%b c%0d",
               tag, a.sync, a.ph, a.eo, a.es, a.eh, a.st, a.cnt,
               e.sync, e.ph, e.eo, e.es, e.eh, e.st, e.cnt);
    end
  endtask

  task automatic drive(
    input string      tag,
    input logic [2:0] l,
    input logic       c,
    input exp_t       e
  );
    bus.light   = l;
    bus.err_clr = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag, sb.pop_front());
    end
  endtask

  initial begin
    logic [2:0] seq [3];
    logic [1:0] phs [3];
    logic [7:0] cnt;
    int         run;
    logic       st;

    seq = '{Y, G, R};
    phs = '{2'b10, 2'b11, 2'b01};

    tbl[0]  = '{Y,      1'b0, mk(1, 2'b10, 0, 0, 0, 0, 10)};
    tbl[1]  = '{3'b011, 1'b0, mk(0, 2'b00, 1, 0, 0, 1, 10)};
    tbl[2]  = '{Y,      1'b0, mk(1, 2'b10, 0, 0, 0, 1, 10)};
    tbl[3]  = '{G,      1'b0, mk(1, 2'b11, 0, 0, 0, 1, 10)};
    tbl[4]  = '{R,      1'b0, mk(1, 2'b01, 0, 0, 0, 1, 11)};
    tbl[5]  = '{G,      1'b0, mk(1, 2'b11, 0, 1, 0, 1, 11)};
    tbl[6]  = '{Y,      1'b0, mk(1, 2'b10, 0, 1, 0, 1, 11)};
    tbl[7]  = '{3'b000, 1'b0, mk(0, 2'b00, 1, 0, 0, 1, 11)};
    tbl[8]  = '{R,      1'b1, mk(1, 2'b01, 0, 0, 0, 0, 11)};
    tbl[9]  = '{Y,      1'b0, mk(1, 2'b10, 0, 0, 0, 0, 11)};
    tbl[10] = '{R,      1'b1, mk(1, 2'b01, 0, 1, 0, 1, 11)};
    tbl[11] = '{Y,      1'b1, mk(1, 2'b10, 0, 0, 0, 0, 11)};
    tbl[12] = '{3'b111, 1'b0, mk(0, 2'b00, 1, 0, 0, 1, 11)};
    tbl[13] = '{3'b110, 1'b0, mk(0, 2'b00, 1, 0, 0, 1, 11)};
    tbl[14] = '{G,      1'b0, mk(1, 2'b11, 0, 0, 0, 1, 11)};
    tbl[15] = '{R,      1'b1, mk(1, 2'b01, 0, 0, 0, 0, 12)};

    bus.light   = 3'b000;
    bus.err_clr = 1'b0;
    #3;
    check("reset", mk(0, 2'b00, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 30; i++)
      drive("rotate", seq[i % 3], 1'b0,
            mk(1, phs[i % 3], 0, 0, 0, 0, 8'((i + 1) / 3)));

    for (int i = 0; i < 16; i++)
      drive($sformatf("vec%0d", i), tbl[i].light,
            tbl[i].clr, tbl[i].e);

    run = 1;
    st  = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      if (HC && run == 4) begin
        run = 0;
        st  = 1'b1;
        drive("hold_err", R, 1'b0, mk(0, 2'b00, 0, 0, 1, 1, 12));
      end else begin
        run = (run == 0) ? 1 : run + 1;
        drive("hold_ok", R, 1'b0, mk(1, 2'b01, 0, 0, 0, st, 12));
      end
    end
    drive("hold_clr", Y, 1'b1, mk(1, 2'b10, 0, 0, 0, 0, 12));
    drive("post_g", G, 1'b0, mk(1, 2'b11, 0, 0, 0, 0, 12));
    drive("post_r", R, 1'b0, mk(1, 2'b01, 0, 0, 0, 0, 13));

    cnt = 8'd13;
    for (int r = 0; r < 246; r++) begin
      drive("wrap_y", Y, 1'b0, mk(1, 2'b10, 0, 0, 0, 0, cnt));
      drive("wrap_g", G, 1'b0, mk(1, 2'b11, 0, 0, 0, 0, cnt));
      cnt = cnt + 8'd1;
      drive("wrap_r", R, 1'b0, mk(1, 2'b01, 0, 0, 0, 0, cnt));
    end
    drive("pre_y", Y, 1'b0, mk(1, 2'b10, 0, 0, 0, 0, 3));
    drive("pre_g", G, 1'b0, mk(1, 2'b11, 0, 0, 0, 0, 3));

    #3;
    rst = 1'b1;
    #1;
    check("async_rst", mk(0, 2'b00, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive("rst_r", R, 1'b0, mk(1, 2'b01, 0, 0, 0, 0, 0));
    drive("rst_y", Y, 1'b0, mk(1, 2'b10, 0, 0, 0, 0, 0));
    drive("rst_g", G, 1'b0, mk(1, 2'b11, 0, 0, 0, 0, 0));
    drive("rst_r2", R, 1'b0, mk(1, 2'b01, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
